shared_buffer_mq: RTL and testbench
===================================

Name: shared_buffer_mq

Overview:
- Multi-queue shared packet-cell buffer: one RAM of 2^ADDR_BITWIDTH cells shared by NUM_QUEUES logical output queues.
- Each queue is a linked list of cells (head/tail pointers plus a next-pointer array).
- Freed cells are recycled through an internal free-address FIFO.
- Sits between the ingress classifier (writes tagged with a queue id) and the per-port egress schedulers (reads by queue id).

Parameters:
- ADDR_BITWIDTH, 4, cell address width; DEPTH = 2^ADDR_BITWIDTH cells.
- DATA_BITWIDTH, 8, cell data width.
- NUM_QUEUES, 4, number of logical queues.
- QID_BITWIDTH, 2, queue id width; must satisfy 2^QID_BITWIDTH >= NUM_QUEUES.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- wr_req  in  1  write one cell.
- wr_qid  in  QID_BITWIDTH  destination queue of the write.
- idata  in  DATA_BITWIDTH  write data.
- wr_ack  out  1  one-cycle pulse: the write was accepted.
- wr_drop  out  1  one-cycle pulse: the write was rejected (buffer full or qid out of range).
- op  out  ADDR_BITWIDTH  cell address used by the last accepted write.
- rd_req  in  1  dequeue one cell.
- rd_qid  in  QID_BITWIDTH  queue to dequeue from.
- odata  out  DATA_BITWIDTH  dequeued data.
- odata_valid  out  1  one-cycle pulse qualifying odata.
- rd_err  out  1  one-cycle pulse: the read was rejected (queue empty or qid out of range).
- q_empty  out  NUM_QUEUES  bit i = 1 when queue i holds no cells.
- full  out  1  all DEPTH cells are in use.
- free_count  out  ADDR_BITWIDTH+1  number of unused cells.

Behaviour:
- Reset (rst=0 at an edge):
  - All queues empty; head/tail/count are 0; free FIFO empty; init counter 0.
  - Outputs: full=0, free_count=DEPTH, q_empty=all ones, op=0, odata=0, and wr_ack, wr_drop, odata_valid, rd_err all 0.
  - Reset mid-operation discards all contents; RAM contents are don't-care.
- Cell allocation:
  - While the init counter < DEPTH, the allocated address is the init counter, which then increments; it saturates at DEPTH.
  - After that, the allocated address is the free-FIFO head, which is popped.
  - The comparison uses DEPTH exactly; there are no fixed-width constants.
- Write, accepted when wr_req=1, full=0 and wr_qid < NUM_QUEUES:
  - At the edge: RAM[addr] <= idata.
  - If the queue is empty: head = tail = addr. Otherwise next[tail] <= addr and tail <= addr.
  - count[qid]++, op <= addr, wr_ack=1 in the following cycle.
  - If wr_req=1 but the write is not accepted: wr_drop=1 and no state change.
- Read, accepted when rd_req=1, rd_qid < NUM_QUEUES and count[rd_qid] != 0:
  - Address = head[qid]; odata <= RAM[head] and odata_valid=1 in the next cycle (latency 1).
  - head <= next[head]; count[qid]--; the address is pushed into the free FIFO.
  - Otherwise: rd_err=1 and no state change.
  - odata holds its value between reads.
- full and free_count are registered and reflect state after the edge.
  - full=1 exactly when free_count=0.
  - free_count changes by +1 on a read, -1 on a write, and 0 on both in the same cycle.
- Simultaneous write and read:
  - Both are evaluated against pre-edge state.
  - A write while full=1 is dropped even if a read frees a cell in the same cycle.
  - Allocation pops the registered free-FIFO head; the freed address is pushed behind it, so no collision occurs.
  - Same queue with count=1: the read returns the old head; the new head equals the written address (bypass, not the stale next[]). The queue remains non-empty with count 1.
  - Same queue with count=0: the read is rejected with rd_err; the write proceeds.
  - Different queues: both proceed independently.
- The free FIFO has depth DEPTH and can never overflow, because the number of freed cells is at most DEPTH.

Test Plan:
- Reset, then 3 writes to q1 (0xA1, 0xA2, 0xA3):
  - Required: op = 0, 1, 2; free_count=13; q_empty=4'b1101.
  - Then 3 reads of q1 return 0xA1, 0xA2, 0xA3 with odata_valid one cycle after each rd_req; q_empty=4'b1111.
- Fill 16 cells alternating q0/q2:
  - Required: full=1 after the 16th write; a 17th write gives wr_drop=1 with no change.
  - Then read one cell from q0 and write again: op equals the freed address 0.
- Queue holds 1 cell (0x55 at address 3); same-cycle read q0 and write 0x66 to q0:
  - Required: odata=0x55; the next read returns 0x66; count stays consistent; free_count unchanged.
- Read from empty q3, and same-cycle write+read to empty q2:
  - Required: rd_err=1 in both cases; the q2 write succeeds; q_empty[2]=0.
- Interleaved traffic on 4 queues over 200 random cycles against a per-queue scoreboard:
  - Required: per-queue FIFO order preserved and free_count matches the model.
  - Assert rst=0 mid-run: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/shared_buffer_mq.sv
// Multi-queue shared cell buffer. One cell RAM is shared by NUM_QUEUES
// linked-list queues. Cells are handed out first from a linear init counter,
// then from a free-address FIFO that collects cells released by reads.
module shared_buffer_mq #(
  parameter int unsigned ADDR_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned NUM_QUEUES    = 4,
  parameter int unsigned QID_BITWIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [QID_BITWIDTH-1:0]  wr_qid,
  input  logic [DATA_BITWIDTH-1:0] idata,
  output logic                     wr_ack,
  output logic                     wr_drop,
  output logic [ADDR_BITWIDTH-1:0] op,
  input  logic                     rd_req,
  input  logic [QID_BITWIDTH-1:0]  rd_qid,
  output logic [DATA_BITWIDTH-1:0] odata,
  output logic                     odata_valid,
  output logic                     rd_err,
  output logic [NUM_QUEUES-1:0]    q_empty,
  output logic                     full,
  output logic [ADDR_BITWIDTH:0]   free_count
);

  localparam int unsigned DEPTH = 1 << ADDR_BITWIDTH;

  typedef logic [ADDR_BITWIDTH-1:0] addr_t;
  typedef logic [ADDR_BITWIDTH:0]   cnt_t;

  localparam cnt_t DepthCnt = cnt_t'(DEPTH);

  // Storage without reset: contents are meaningless until linked into a queue.
  logic [DATA_BITWIDTH-1:0] ram_q  [DEPTH];
  addr_t                    nxt_q  [DEPTH];
  addr_t                    fifo_q [DEPTH];

  addr_t fifo_rd_q, fifo_wr_q;
  cnt_t  init_q;
  addr_t head_q [NUM_QUEUES];
  addr_t tail_q [NUM_QUEUES];
  cnt_t  cnt_q  [NUM_QUEUES];
  cnt_t  cnt_d  [NUM_QUEUES];

  logic  wr_qid_ok, rd_qid_ok, wr_ok, rd_ok, from_init, same_q;
  addr_t alloc_addr, rd_addr;
  cnt_t  free_d;

  // Accept decisions, all taken against pre-edge state.
  always_comb begin
    wr_qid_ok  = 32'(wr_qid) < NUM_QUEUES;
    rd_qid_ok  = 32'(rd_qid) < NUM_QUEUES;
    wr_ok      = wr_req && !full && wr_qid_ok;
    rd_ok      = rd_req && rd_qid_ok && (cnt_q[rd_qid] != '0);
    from_init  = init_q < DepthCnt;
    alloc_addr = from_init ? init_q[ADDR_BITWIDTH-1:0] : fifo_q[fifo_rd_q];
    rd_addr    = head_q[rd_qid];
    same_q     = wr_ok && rd_ok && (wr_qid == rd_qid);
  end

  // Per-queue occupancy and total free-cell count after this edge.
  always_comb begin
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_ok && 32'(wr_qid) == i) cnt_d[i] = cnt_d[i] + cnt_t'(1);
      if (rd_ok && 32'(rd_qid) == i) cnt_d[i] = cnt_d[i] - cnt_t'(1);
    end
    free_d = free_count;
    if (wr_ok && !rd_ok)      free_d = free_count - cnt_t'(1);
    else if (rd_ok && !wr_ok) free_d = free_count + cnt_t'(1);
  end

  // Empty flags follow the registered counts directly.
  always_comb begin
    for (int unsigned i = 0; i < NUM_QUEUES; i++) q_empty[i] = (cnt_q[i] == '0);
  end

  // Data RAM, next-pointer array and free-FIFO storage writes.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ram_q[alloc_addr] <= idata;
      if (cnt_q[wr_qid] != '0) nxt_q[tail_q[wr_qid]] <= alloc_addr;
    end
    if (rd_ok) fifo_q[fifo_wr_q] <= rd_addr;
  end

  // Queue pointers, allocator state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      init_q      <= '0;
      fifo_rd_q   <= '0;
      fifo_wr_q   <= '0;
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      full        <= 1'b0;
      free_count  <= DepthCnt;
      op          <= '0;
      odata       <= '0;
      wr_ack      <= 1'b0;
      wr_drop     <= 1'b0;
      odata_valid <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      wr_ack      <= wr_ok;
      wr_drop     <= wr_req && !wr_ok;
      odata_valid <= rd_ok;
      rd_err      <= rd_req && !rd_ok;
      free_count  <= free_d;
      full        <= (free_d == '0);
      for (int unsigned i = 0; i < NUM_QUEUES; i++) cnt_q[i] <= cnt_d[i];

      if (wr_ok) begin
        op <= alloc_addr;
        if (from_init) init_q    <= init_q + cnt_t'(1);
        else           fifo_rd_q <= fifo_rd_q + addr_t'(1);
        // A write into an empty queue cannot collide with a read of it.
        if (cnt_q[wr_qid] == '0) head_q[wr_qid] <= alloc_addr;
        tail_q[wr_qid] <= alloc_addr;
      end

      if (rd_ok) begin
        odata     <= ram_q[rd_addr];
        fifo_wr_q <= fifo_wr_q + addr_t'(1);
        // Last cell leaving while a new one arrives: next[] is not yet written.
        if (same_q && cnt_q[rd_qid] == cnt_t'(1)) head_q[rd_qid] <= alloc_addr;
        else                                      head_q[rd_qid] <= nxt_q[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_shared_buffer_mq.sv
// Directed and scoreboarded bench for shared_buffer_mq.
module tb_shared_buffer_mq;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req;
  logic [1:0] wr_qid, rd_qid;
  logic [7:0] idata, odata;
  logic       wr_ack, wr_drop, odata_valid, rd_err, full;
  logic [3:0] op, q_empty;
  logic [4:0] free_count;

  int n_pass = 0;
  int n_total = 0;

  shared_buffer_mq dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_qid(wr_qid), .idata(idata), .wr_ack(wr_ack), .wr_drop(wr_drop),
    .op(op),
    .rd_req(rd_req), .rd_qid(rd_qid), .odata(odata), .odata_valid(odata_valid),
    .rd_err(rd_err), .q_empty(q_empty), .full(full), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // One clock with the given requests; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic w, input logic [1:0] wq, input logic [7:0] d,
                      input logic r, input logic [1:0] rq);
    wr_req = w; wr_qid = wq; idata = d; rd_req = r; rd_qid = rq;
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_qid = '0; rd_qid = '0; idata = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_total++; if (free_count !== 5'd16) $display("FAIL reset_free got %0d want 16", free_count);
    else n_pass++;
    n_total++; if (q_empty !== 4'hf) $display("FAIL reset_qempty got %b want 1111", q_empty);
    else n_pass++;
    n_total++; if (op !== 4'd0 || odata !== 8'd0)
      $display("FAIL reset_op_odata got %h/%h want 0/00", op, odata); else n_pass++;
    n_total++; if ({wr_ack, wr_drop, odata_valid, rd_err} !== 4'b0)
      $display("FAIL reset_pulses got %b want 0000", {wr_ack, wr_drop, odata_valid, rd_err});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_d = 8'hA1 + 8'(i);
      step(1'b1, 2'd1, exp_d, 1'b0, 2'd0);
      n_total++; if (wr_ack !== 1'b1 || op !== 4'(i))
        $display("FAIL basic_write%0d got ack=%b op=%0d want ack=1 op=%0d", i, wr_ack, op, i);
      else n_pass++;
    end
    n_total++; if (free_count !== 5'd13) $display("FAIL basic_free got %0d want 13", free_count);
    else n_pass++;
    n_total++; if (q_empty !== 4'b1101) $display("FAIL basic_qempty got %b want 1101", q_empty);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp_d = 8'hA1 + 8'(i);
      step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
      n_total++; if (odata_valid !== 1'b1 || odata !== exp_d)
        $display("FAIL basic_read%0d got v=%b d=%h want v=1 d=%h", i, odata_valid, odata, exp_d);
      else n_pass++;
    end
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    n_total++; if (odata_valid !== 1'b0 || odata !== 8'hA3)
      $display("FAIL basic_hold got v=%b d=%h want v=0 d=a3", odata_valid, odata); else n_pass++;
    n_total++; if (q_empty !== 4'b1111 || free_count !== 5'd16)
      $display("FAIL basic_drain got qe=%b free=%0d want 1111/16", q_empty, free_count);
    else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2 == 0) ? 2'd0 : 2'd2, 8'h10 + 8'(i), 1'b0, 2'd0);
    n_total++; if (full !== 1'b1 || free_count !== 5'd0 || op !== 4'd15)
      $display("FAIL full_after16 got full=%b free=%0d op=%0d want 1/0/15", full, free_count, op);
    else n_pass++;
    step(1'b1, 2'd1, 8'hFF, 1'b0, 2'd0);
    n_total++; if (wr_drop !== 1'b1 || wr_ack !== 1'b0 || op !== 4'd15 || free_count !== 5'd0)
      $display("FAIL full_drop got drop=%b ack=%b op=%0d free=%0d want 1/0/15/0",
               wr_drop, wr_ack, op, free_count);
    else n_pass++;
    n_total++; if (q_empty[1] !== 1'b1) $display("FAIL full_drop_q1 got %b want 1", q_empty[1]);
    else n_pass++;
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    n_total++; if (odata !== 8'h10 || full !== 1'b0 || free_count !== 5'd1)
      $display("FAIL full_read got d=%h full=%b free=%0d want 10/0/1", odata, full, free_count);
    else n_pass++;
    step(1'b1, 2'd1, 8'hEE, 1'b0, 2'd0);
    n_total++; if (wr_ack !== 1'b1 || op !== 4'd0 || full !== 1'b1)
      $display("FAIL full_reuse got ack=%b op=%0d full=%b want 1/0/1", wr_ack, op, full);
    else n_pass++;
    // Full: the write is dropped even though the read frees a cell this cycle.
    step(1'b1, 2'd3, 8'hDD, 1'b1, 2'd2);
    n_total++; if (wr_drop !== 1'b1 || odata_valid !== 1'b1 || odata !== 8'h11 ||
                   free_count !== 5'd1)
      $display("FAIL full_rw got drop=%b v=%b d=%h free=%0d want 1/1/11/1",
               wr_drop, odata_valid, odata, free_count);
    else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 8'h30 + 8'(i), 1'b0, 2'd0);
    step(1'b1, 2'd0, 8'h55, 1'b0, 2'd0);
    n_total++; if (op !== 4'd3) $display("FAIL bypass_addr got %0d want 3", op); else n_pass++;
    step(1'b1, 2'd0, 8'h66, 1'b1, 2'd0);
    n_total++; if (odata_valid !== 1'b1 || odata !== 8'h55 || wr_ack !== 1'b1 || op !== 4'd4)
      $display("FAIL bypass_rw got v=%b d=%h ack=%b op=%0d want 1/55/1/4",
               odata_valid, odata, wr_ack, op);
    else n_pass++;
    n_total++; if (free_count !== 5'd12 || q_empty[0] !== 1'b0)
      $display("FAIL bypass_state got free=%0d qe0=%b want 12/0", free_count, q_empty[0]);
    else n_pass++;
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    n_total++; if (odata !== 8'h66 || q_empty[0] !== 1'b1)
      $display("FAIL bypass_next got d=%h qe0=%b want 66/1", odata, q_empty[0]); else n_pass++;
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    n_total++; if (rd_err !== 1'b1 || odata_valid !== 1'b0)
      $display("FAIL bypass_empty got err=%b v=%b want 1/0", rd_err, odata_valid); else n_pass++;
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    n_total++; if (odata !== 8'h30) $display("FAIL bypass_q3 got %h want 30", odata);
    else n_pass++;
  endtask

  task automatic test_empty();
    do_reset();
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    n_total++; if (rd_err !== 1'b1 || odata_valid !== 1'b0 || free_count !== 5'd16)
      $display("FAIL empty_q3 got err=%b v=%b free=%0d want 1/0/16", rd_err, odata_valid,
               free_count);
    else n_pass++;
    step(1'b1, 2'd2, 8'h77, 1'b1, 2'd2);
    n_total++; if (rd_err !== 1'b1 || wr_ack !== 1'b1 || q_empty !== 4'b1011)
      $display("FAIL empty_rw got err=%b ack=%b qe=%b want 1/1/1011", rd_err, wr_ack, q_empty);
    else n_pass++;
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    n_total++; if (odata_valid !== 1'b1 || odata !== 8'h77)
      $display("FAIL empty_readback got v=%b d=%h want 1/77", odata_valid, odata); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] sb [4][$];
    int         mfree;
    logic       w, r, exp_ack, exp_rv;
    logic [1:0] wq, rq;
    logic [7:0] d, exp_d;
    logic [3:0] exp_qe;
    do_reset();
    mfree = 16;
    exp_d = 8'h00;
    for (int c = 0; c < 200; c++) begin
      w  = ($urandom_range(9) < 6);
      r  = ($urandom_range(9) < 5);
      wq = 2'($urandom_range(3));
      rq = 2'($urandom_range(3));
      d  = 8'($urandom);
      if (c == 100) begin
        rst = 1'b0;
        step(w, wq, d, r, rq);
        rst = 1'b1;
        for (int q = 0; q < 4; q++) sb[q].delete();
        mfree = 16;
        exp_d = 8'h00;
        n_total++; if ({wr_ack, wr_drop, odata_valid, rd_err} !== 4'b0 || full !== 1'b0 ||
                       free_count !== 5'd16 || q_empty !== 4'hf || op !== 4'd0 || odata !== 8'd0)
          $display("FAIL rand_midreset got pulses=%b full=%b free=%0d qe=%b op=%0d d=%h",
                   {wr_ack, wr_drop, odata_valid, rd_err}, full, free_count, q_empty, op, odata);
        else n_pass++;
      end else begin
        exp_rv  = r && (sb[rq].size() != 0);
        exp_ack = w && (mfree != 0);
        if (exp_rv) begin exp_d = sb[rq].pop_front(); mfree++; end
        if (exp_ack) begin sb[wq].push_back(d); mfree--; end
        step(w, wq, d, r, rq);
        for (int q = 0; q < 4; q++) exp_qe[q] = (sb[q].size() == 0);
        n_total++; if (wr_ack !== exp_ack || wr_drop !== (w && !exp_ack) ||
                       odata_valid !== exp_rv || rd_err !== (r && !exp_rv))
          $display("FAIL rand_pulses c=%0d got %b%b%b%b want %b%b%b%b", c, wr_ack, wr_drop,
                   odata_valid, rd_err, exp_ack, w && !exp_ack, exp_rv, r && !exp_rv);
        else n_pass++;
        n_total++; if (odata !== exp_d)
          $display("FAIL rand_odata c=%0d got %h want %h", c, odata, exp_d); else n_pass++;
        n_total++; if (free_count !== 5'(mfree) || full !== (mfree == 0) || q_empty !== exp_qe)
          $display("FAIL rand_state c=%0d got free=%0d full=%b qe=%b want %0d/%b/%b", c,
                   free_count, full, q_empty, mfree, mfree == 0, exp_qe);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_bypass();
    test_empty();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
